// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master frame sequencer: state encoding and
// the bit positions of the spi_master control/status registers.
package spi_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

    localparam int CTRL_START_BIT = 7;
    localparam int STAT_BUSY_BIT  = 7;
    localparam int FIFO_W         = 128;

endpackage

// File: rtl/spi_unit_unpacker.sv
// Holds a snapshot of the spi_master receive FIFO and hands it out MSB-first,
// one W-bit unit per valid/ready handshake, flagging the unit at index len.
module spi_unit_unpacker
    import spi_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [FIFO_W-1:0] fifo,
    input  logic [3:0]        len,
    input  logic              rx_ready,
    output logic              rx_valid,
    output logic [15:0]       rx_data,
    output logic              rx_last,
    output logic              done
);

    logic [FIFO_W-1:0] shadow;
    logic [3:0]        idx;
    logic [3:0]        len_q;

    assign done = rx_valid & rx_ready & rx_last;

    // The shadow is pre-shifted so the next unit always sits in the top W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            idx      <= '0;
            len_q    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_last  <= 1'b0;
        end else if (load) begin
            shadow   <= fifo << W;
            idx      <= '0;
            len_q    <= len;
            rx_valid <= 1'b1;
            rx_data  <= 16'(fifo[FIFO_W-1 -: W]);
            rx_last  <= (len == 4'd0);
        end else if (rx_valid && rx_ready) begin
            if (rx_last) begin
                rx_valid <= 1'b0;
                rx_last  <= 1'b0;
            end else begin
                shadow  <= shadow << W;
                idx     <= idx + 4'd1;
                rx_data <= 16'(shadow[FIFO_W-1 -: W]);
                rx_last <= (idx + 4'd1 == len_q);
            end
        end
    end

endmodule

// File: rtl/spi_mst_frame_seq.sv
// Packs a tx unit stream into the spi_master write FIFO, launches the transfer,
// follows busy, then streams the captured read FIFO back out as rx units.
module spi_mst_frame_seq
    import spi_pkg::*;
#(
    parameter bit MODE_16B = 1'b0,
    parameter int START_TO = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [15:0]       tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [15:0]       rx_data,
    output logic              rx_last,
    output logic [FIFO_W-1:0] mst_wfifo,
    output logic [7:0]        mst_ctrl,
    input  logic [FIFO_W-1:0] mst_rfifo,
    input  logic [7:0]        mst_status,
    output logic              err_to
);

    localparam int         W        = MODE_16B ? 16 : 8;
    localparam int         MAX      = MODE_16B ? 8 : 16;
    localparam logic [4:0] CNT_LAST = 5'(MAX - 1);
    localparam logic [9:0] TO_LAST  = 10'(START_TO - 1);

    seq_state_e  state, next_state;
    logic [4:0]  cnt;
    logic [3:0]  len;
    logic [9:0]  to_cnt;
    logic        start;
    logic        ready_d, start_d;
    logic        busy, tx_fire, launch, to_hit, rx_done, load;
    logic        unused_bits;

    assign busy        = mst_status[STAT_BUSY_BIT];
    assign tx_fire     = tx_valid & tx_ready;
    assign launch      = tx_fire & (tx_last | (cnt == CNT_LAST));
    assign to_hit      = (to_cnt == TO_LAST);
    assign load        = (state == BUSY) && !busy;
    assign unused_bits = ^{mst_status, tx_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            tx_ready <= 1'b1;
            start    <= 1'b0;
        end else begin
            state    <= next_state;
            tx_ready <= ready_d;
            start    <= start_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (launch) next_state = START;
            START:   if (busy) next_state = BUSY;
                     else if (to_hit) next_state = FILL;
            BUSY:    if (!busy) next_state = DRAIN;
            DRAIN:   if (rx_done) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    // Handshake outputs are decoded from the next state so they are registered.
    always_comb begin
        ready_d = (next_state == FILL);
        start_d = (next_state == START);
    end

    always_comb begin
        mst_ctrl                 = '0;
        mst_ctrl[3:0]            = len;
        mst_ctrl[CTRL_START_BIT] = start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            len       <= '0;
            to_cnt    <= '0;
            err_to    <= 1'b0;
            mst_wfifo <= '0;
        end else begin
            to_cnt <= (state == START) ? to_cnt + 10'd1 : 10'd0;
            if (tx_fire) begin
                err_to <= 1'b0;
                cnt    <= cnt + 5'd1;
                for (int k = 0; k < MAX; k++) begin
                    if (cnt == 5'(k)) mst_wfifo[FIFO_W-1-W*k -: W] <= tx_data[W-1:0];
                end
                if (launch) len <= cnt[3:0];
            end
            if (state == START && !busy && to_hit) begin
                err_to <= 1'b1;
                cnt    <= '0;
            end
            if (rx_done) cnt <= '0;
        end
    end

    spi_unit_unpacker #(.W(W)) u_unpacker (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .fifo     (mst_rfifo),
        .len      (len),
        .rx_ready (rx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_last  (rx_last),
        .done     (rx_done)
    );

endmodule

// File: tb/tb_spi_mst_frame_seq.sv
// Directed bench for spi_mst_frame_seq: an 8-bit and a 16-bit instance, each
// driven against a small spi_master stub that returns {4{32'hCAFE_EFAB}}.
module tb_spi_mst_frame_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         tx_valid   [2];
    logic         tx_ready   [2];
    logic [15:0]  tx_data    [2];
    logic         tx_last    [2];
    logic         rx_valid   [2];
    logic         rx_ready   [2];
    logic [15:0]  rx_data    [2];
    logic         rx_last    [2];
    logic [127:0] mst_wfifo  [2];
    logic [7:0]   mst_ctrl   [2];
    logic         err_to     [2];
    logic         stub_busy  [2] = '{1'b0, 1'b0};
    logic         stub_en    [2];
    int           phase      [2] = '{0, 0};
    int           cyc        [2] = '{0, 0};
    logic [127:0] rfifo = {4{32'hCAFE_EFAB}};
    logic [7:0]   pat        [4] = '{8'hCA, 8'hFE, 8'hEF, 8'hAB};

    int compared   = 0;
    int mismatched = 0;

    spi_mst_frame_seq #(.MODE_16B(1'b0), .START_TO(1023)) dut8 (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_data(tx_data[0]), .tx_last(tx_last[0]),
        .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .rx_data(rx_data[0]), .rx_last(rx_last[0]),
        .mst_wfifo(mst_wfifo[0]), .mst_ctrl(mst_ctrl[0]), .mst_rfifo(rfifo),
        .mst_status({stub_busy[0], 7'b0}), .err_to(err_to[0])
    );

    spi_mst_frame_seq #(.MODE_16B(1'b1), .START_TO(1023)) dut16 (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_data(tx_data[1]), .tx_last(tx_last[1]),
        .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .rx_data(rx_data[1]), .rx_last(rx_last[1]),
        .mst_wfifo(mst_wfifo[1]), .mst_ctrl(mst_ctrl[1]), .mst_rfifo(rfifo),
        .mst_status({stub_busy[1], 7'b0}), .err_to(err_to[1])
    );

    // spi_master stub: busy rises 3 cycles after start is seen, holds for 40 cycles.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            case (phase[s])
                0: if (mst_ctrl[s][7] && stub_en[s]) begin
                       phase[s] <= 1;
                       cyc[s]   <= 1;
                   end
                1: if (cyc[s] == 3) begin
                       stub_busy[s] <= 1'b1;
                       phase[s]     <= 2;
                       cyc[s]       <= 1;
                   end else cyc[s] <= cyc[s] + 1;
                default: if (cyc[s] == 40) begin
                       stub_busy[s] <= 1'b0;
                       phase[s]     <= 0;
                   end else cyc[s] <= cyc[s] + 1;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int s, input logic [15:0] d, input logic last);
        int n = 0;
        tx_valid[s] = 1'b1;
        tx_data[s]  = d;
        tx_last[s]  = last;
        while (!tx_ready[s] && n < 2000) begin
            step();
            n++;
        end
        if (!tx_ready[s]) checkOutput("tx_ready_wait", 128'(tx_ready[s]), 128'(1));
        step();
        tx_valid[s] = 1'b0;
        tx_last[s]  = 1'b0;
    endtask

    task automatic waitBusy(input int s, input logic lvl);
        int n = 0;
        while (stub_busy[s] !== lvl && n < 200) begin
            step();
            n++;
        end
        if (stub_busy[s] !== lvl) checkOutput("busy_wait", 128'(stub_busy[s]), 128'(lvl));
    endtask

    // Follows a launched frame to the first rx unit and checks the busy-edge timing.
    task automatic awaitDrain(input int s, input logic [7:0] ctrl_run);
        waitBusy(s, 1'b1);
        step();
        checkOutput("ctrl_run", 128'(mst_ctrl[s]), 128'(ctrl_run));
        checkOutput("tx_ready_busy", 128'(tx_ready[s]), 128'(0));
        waitBusy(s, 1'b0);
        checkOutput("rx_valid_pre", 128'(rx_valid[s]), 128'(0));
        step();
        checkOutput("rx_valid_lat", 128'(rx_valid[s]), 128'(1));
    endtask

    task automatic recvUnit(input int s, input logic [15:0] d, input logic last);
        int n = 0;
        rx_ready[s] = 1'b1;
        while (!rx_valid[s] && n < 200) begin
            step();
            n++;
        end
        checkOutput("rx_data", 128'(rx_data[s]), 128'(d));
        checkOutput("rx_last", 128'(rx_last[s]), 128'(last));
        step();
    endtask

    task automatic checkReset(input int s);
        checkOutput("rst_tx_ready", 128'(tx_ready[s]), 128'(1));
        checkOutput("rst_rx_valid", 128'(rx_valid[s]), 128'(0));
        checkOutput("rst_rx_last", 128'(rx_last[s]), 128'(0));
        checkOutput("rst_rx_data", 128'(rx_data[s]), 128'(0));
        checkOutput("rst_ctrl", 128'(mst_ctrl[s]), 128'(0));
        checkOutput("rst_wfifo", mst_wfifo[s], 128'(0));
        checkOutput("rst_err_to", 128'(err_to[s]), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int s = 0; s < 2; s++) begin
            tx_valid[s] = 1'b0;
            tx_data[s]  = '0;
            tx_last[s]  = 1'b0;
            rx_ready[s] = 1'b1;
            stub_en[s]  = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkReset(0);
        checkReset(1);
        rst = 1'b0;
        step();

        $display("[TB] 8-bit four-unit frame");
        applyStimulus(0, 16'h00CA, 1'b0);
        applyStimulus(0, 16'h00FE, 1'b0);
        applyStimulus(0, 16'h00EF, 1'b0);
        applyStimulus(0, 16'h00AB, 1'b1);
        checkOutput("ctrl_launch4", 128'(mst_ctrl[0]), 128'(8'h83));
        checkOutput("tx_ready_start", 128'(tx_ready[0]), 128'(0));
        checkOutput("wfifo4", 128'(mst_wfifo[0][127:96]), 128'(32'hCAFE_EFAB));
        awaitDrain(0, 8'h03);
        for (int i = 0; i < 4; i++) recvUnit(0, 16'(pat[i]), i == 3);
        checkOutput("tx_ready_after", 128'(tx_ready[0]), 128'(1));
        checkOutput("rx_valid_after", 128'(rx_valid[0]), 128'(0));

        $display("[TB] 8-bit sixteen-unit auto launch with backpressure");
        rx_ready[0] = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(0, 16'(8'h10 + i), 1'b0);
        checkOutput("ctrl_launch16", 128'(mst_ctrl[0]), 128'(8'h8F));
        checkOutput("wfifo16_first", 128'(mst_wfifo[0][127:120]), 128'(8'h10));
        checkOutput("wfifo16_last", 128'(mst_wfifo[0][7:0]), 128'(8'h1F));
        awaitDrain(0, 8'h0F);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("bp_rx_data", 128'(rx_data[0]), 128'(8'hCA));
            checkOutput("bp_rx_valid", 128'(rx_valid[0]), 128'(1));
        end
        for (int i = 0; i < 16; i++) recvUnit(0, 16'(pat[i % 4]), i == 15);
        checkOutput("rx_valid_after16", 128'(rx_valid[0]), 128'(0));
        applyStimulus(0, 16'h0055, 1'b0);
        checkOutput("frame17_ready", 128'(tx_ready[0]), 128'(1));
        checkOutput("frame17_start", 128'(mst_ctrl[0][7]), 128'(0));
        checkOutput("frame17_wfifo", 128'(mst_wfifo[0][127:120]), 128'(8'h55));
        applyStimulus(0, 16'h0066, 1'b1);
        checkOutput("frame17_ctrl", 128'(mst_ctrl[0]), 128'(8'h81));
        awaitDrain(0, 8'h01);
        recvUnit(0, 16'h00CA, 1'b0);
        recvUnit(0, 16'h00FE, 1'b1);

        $display("[TB] 16-bit two-unit frame");
        applyStimulus(1, 16'hBABE, 1'b0);
        applyStimulus(1, 16'hFACE, 1'b1);
        checkOutput("ctrl16", 128'(mst_ctrl[1]), 128'(8'h81));
        checkOutput("wfifo16b", 128'(mst_wfifo[1][127:96]), 128'(32'hBABE_FACE));
        awaitDrain(1, 8'h01);
        recvUnit(1, 16'hCAFE, 1'b0);
        recvUnit(1, 16'hEFAB, 1'b1);

        $display("[TB] start timeout");
        stub_en[0] = 1'b0;
        applyStimulus(0, 16'h0011, 1'b1);
        n = 0;
        while (mst_ctrl[0][7] && n < 1100) begin
            n++;
            step();
        end
        checkOutput("to_start_cycles", 128'(n), 128'(1023));
        checkOutput("to_err_set", 128'(err_to[0]), 128'(1));
        checkOutput("to_ctrl_start", 128'(mst_ctrl[0][7]), 128'(0));
        checkOutput("to_tx_ready", 128'(tx_ready[0]), 128'(1));
        checkOutput("to_rx_valid", 128'(rx_valid[0]), 128'(0));
        applyStimulus(0, 16'h0022, 1'b0);
        checkOutput("to_err_clear", 128'(err_to[0]), 128'(0));
        stub_en[0] = 1'b1;
        applyStimulus(0, 16'h0033, 1'b1);
        checkOutput("to_next_ctrl", 128'(mst_ctrl[0]), 128'(8'h81));
        checkOutput("to_next_wfifo", 128'(mst_wfifo[0][127:112]), 128'(16'h2233));
        awaitDrain(0, 8'h01);
        recvUnit(0, 16'h00CA, 1'b0);
        recvUnit(0, 16'h00FE, 1'b1);

        $display("[TB] reset during START and during BUSY");
        stub_en[0] = 1'b0;
        applyStimulus(0, 16'h0077, 1'b1);
        step();
        checkOutput("rs_start_high", 128'(mst_ctrl[0][7]), 128'(1));
        rst = 1'b1;
        #1;
        checkOutput("rs_start_async", 128'(mst_ctrl[0]), 128'(0));
        step();
        rst = 1'b0;
        stub_en[0] = 1'b1;
        step();
        applyStimulus(0, 16'h0044, 1'b1);
        waitBusy(0, 1'b1);
        repeat (5) step();
        checkOutput("rb_ctrl_busy", 128'(mst_ctrl[0]), 128'(8'h00));
        checkOutput("rb_wfifo_busy", 128'(mst_wfifo[0][127:120]), 128'(8'h44));
        rst = 1'b1;
        #1;
        checkReset(0);
        step();
        step();
        rst = 1'b0;
        waitBusy(0, 1'b0);
        repeat (3) step();
        checkOutput("rb_no_rx", 128'(rx_valid[0]), 128'(0));
        checkOutput("rb_ready", 128'(tx_ready[0]), 128'(1));
        applyStimulus(0, 16'h00A1, 1'b0);
        applyStimulus(0, 16'h00A2, 1'b1);
        checkOutput("rb_ctrl", 128'(mst_ctrl[0]), 128'(8'h81));
        checkOutput("rb_wfifo", 128'(mst_wfifo[0][127:112]), 128'(16'hA1A2));
        awaitDrain(0, 8'h01);
        recvUnit(0, 16'h00CA, 1'b0);
        recvUnit(0, 16'h00FE, 1'b1);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
